// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: one cipher key in, round keys 0..10 out.
// One shared S-box, 4 SUB cycles plus a load edge per round key.
module aes_key_expander (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] key_in0,
    input  logic [7:0] key_in1,
    input  logic [7:0] key_in2,
    input  logic [7:0] key_in3,
    input  logic [7:0] key_in4,
    input  logic [7:0] key_in5,
    input  logic [7:0] key_in6,
    input  logic [7:0] key_in7,
    input  logic [7:0] key_in8,
    input  logic [7:0] key_in9,
    input  logic [7:0] key_in10,
    input  logic [7:0] key_in11,
    input  logic [7:0] key_in12,
    input  logic [7:0] key_in13,
    input  logic [7:0] key_in14,
    input  logic [7:0] key_in15,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] round_key_out0,
    output logic [7:0] round_key_out1,
    output logic [7:0] round_key_out2,
    output logic [7:0] round_key_out3,
    output logic [7:0] round_key_out4,
    output logic [7:0] round_key_out5,
    output logic [7:0] round_key_out6,
    output logic [7:0] round_key_out7,
    output logic [7:0] round_key_out8,
    output logic [7:0] round_key_out9,
    output logic [7:0] round_key_out10,
    output logic [7:0] round_key_out11,
    output logic [7:0] round_key_out12,
    output logic [7:0] round_key_out13,
    output logic [7:0] round_key_out14,
    output logic [7:0] round_key_out15,
    output logic [3:0] round_idx,
    output logic       rkey_valid,
    input  logic       rkey_ready,
    output logic       busy
);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, OUT, SUB} state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0][7:0]  rk;
    logic [15:0][7:0]  rk_new;
    logic [15:0][7:0]  key_b;
    logic [3:0][7:0]   sub;
    logic [3:0][7:0]   rot;
    logic [3:0][7:0]   temp;
    logic [3:0][7:0]   acc;
    logic [1:0]        sub_cnt;
    logic [7:0]        sbox_in;
    logic [7:0]        sbox_out;
    logic [7:0]        rcon;

    assign key_b = {key_in15, key_in14, key_in13, key_in12,
                    key_in11, key_in10, key_in9,  key_in8,
                    key_in7,  key_in6,  key_in5,  key_in4,
                    key_in3,  key_in2,  key_in1,  key_in0};

    assign round_key_out0  = rk[0];
    assign round_key_out1  = rk[1];
    assign round_key_out2  = rk[2];
    assign round_key_out3  = rk[3];
    assign round_key_out4  = rk[4];
    assign round_key_out5  = rk[5];
    assign round_key_out6  = rk[6];
    assign round_key_out7  = rk[7];
    assign round_key_out8  = rk[8];
    assign round_key_out9  = rk[9];
    assign round_key_out10 = rk[10];
    assign round_key_out11 = rk[11];
    assign round_key_out12 = rk[12];
    assign round_key_out13 = rk[13];
    assign round_key_out14 = rk[14];
    assign round_key_out15 = rk[15];

    assign key_ready  = (state == IDLE);
    assign rkey_valid = (state == OUT);
    assign busy       = (state != IDLE);

    // RotWord(w3): byte j of rot feeds the S-box in SUB cycle j.
    assign rot      = {rk[12], rk[15], rk[14], rk[13]};
    assign sbox_in  = rot[sub_cnt];
    assign sbox_out = SBOX[{~sbox_in, 3'b000} +: 8];

    always_comb begin
        rcon = 8'h00;
        case (round_idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Byte 3 of SubWord is still on the S-box output in the load cycle.
    always_comb begin
        temp   = {sbox_out, sub[2], sub[1], sub[0] ^ rcon};
        acc    = temp;
        rk_new = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc ^ rk[4*k +: 4];
            rk_new[4*k +: 4] = acc;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (key_valid) state_next = OUT;
            OUT: begin
                if (rkey_ready)
                    state_next = (round_idx == 4'd10) ? IDLE : SUB;
            end
            SUB: if (sub_cnt == 2'd3) state_next = OUT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rk        <= '0;
            round_idx <= 4'd0;
            sub       <= '0;
            sub_cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        rk        <= key_b;
                        round_idx <= 4'd0;
                    end
                end
                OUT: if (rkey_ready) sub_cnt <= 2'd0;
                SUB: begin
                    sub[sub_cnt] <= sbox_out;
                    sub_cnt      <= sub_cnt + 2'd1;
                    if (sub_cnt == 2'd3) begin
                        rk        <= rk_new;
                        round_idx <= round_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 A.1 and all-zero keys.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_key_expander;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic [7:0]   ro [16];
    logic [127:0] rk_out;
    logic [3:0]   round_idx;
    logic         rkey_valid;
    logic         rkey_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] a1 [11];
    logic [127:0] zero_r1  = 128'h62636363626363636263636362636363;
    logic [127:0] zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 sys_clk = ~sys_clk;

    assign rk_out = {ro[0], ro[1], ro[2],  ro[3],  ro[4],  ro[5],  ro[6],  ro[7],
                     ro[8], ro[9], ro[10], ro[11], ro[12], ro[13], ro[14], ro[15]};

    aes_key_expander dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .key_in0         (key[127:120]),
        .key_in1         (key[119:112]),
        .key_in2         (key[111:104]),
        .key_in3         (key[103:96]),
        .key_in4         (key[95:88]),
        .key_in5         (key[87:80]),
        .key_in6         (key[79:72]),
        .key_in7         (key[71:64]),
        .key_in8         (key[63:56]),
        .key_in9         (key[55:48]),
        .key_in10        (key[47:40]),
        .key_in11        (key[39:32]),
        .key_in12        (key[31:24]),
        .key_in13        (key[23:16]),
        .key_in14        (key[15:8]),
        .key_in15        (key[7:0]),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .round_key_out0  (ro[0]),
        .round_key_out1  (ro[1]),
        .round_key_out2  (ro[2]),
        .round_key_out3  (ro[3]),
        .round_key_out4  (ro[4]),
        .round_key_out5  (ro[5]),
        .round_key_out6  (ro[6]),
        .round_key_out7  (ro[7]),
        .round_key_out8  (ro[8]),
        .round_key_out9  (ro[9]),
        .round_key_out10 (ro[10]),
        .round_key_out11 (ro[11]),
        .round_key_out12 (ro[12]),
        .round_key_out13 (ro[13]),
        .round_key_out14 (ro[14]),
        .round_key_out15 (ro[15]),
        .round_idx       (round_idx),
        .rkey_valid      (rkey_valid),
        .rkey_ready      (rkey_ready),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_round(input string tag, input int r,
                               input logic [127:0] exp);
        check({tag, " key"}, rk_out, exp);
        check({tag, " idx"}, 128'(round_idx), 128'(r));
        check({tag, " valid"}, 128'(rkey_valid), 128'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " key_ready"}, 128'(key_ready), 128'd1);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " rkey_valid"}, 128'(rkey_valid), 128'd0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Presents k for one edge; returns at the negedge of cycle 1.
    task automatic load_key(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        @(negedge sys_clk);
        key_valid = 1'b0;
    endtask

    initial begin
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset held with a key offered: reset must win.
        sys_rst    = 1'b1;
        key        = a1[0];
        key_valid  = 1'b1;
        rkey_ready = 1'b1;
        wait_cyc(3);
        check("rst key", rk_out, 128'd0);
        check("rst idx", 128'(round_idx), 128'd0);
        check_idle("rst");
        key_valid = 1'b0;
        sys_rst   = 1'b0;
        wait_cyc(2);
        check_idle("post rst");

        // A.1 key, consumer always ready.
        load_key(a1[0]);
        check_round("a1 r0", 0, a1[0]);
        check("a1 r0 key_ready", 128'(key_ready), 128'd0);
        check("a1 r0 busy", 128'(busy), 128'd1);
        wait_cyc(1);
        check("a1 sub valid", 128'(rkey_valid), 128'd0);
        check("a1 sub busy", 128'(busy), 128'd1);
        wait_cyc(4);
        check_round("a1 r1", 1, a1[1]);
        for (int r = 2; r <= 10; r++) begin
            wait_cyc(5);
            check_round($sformatf("a1 r%0d", r), r, a1[r]);
        end
        wait_cyc(1);
        check_idle("a1 done");

        // All-zero key.
        load_key(128'd0);
        check_round("zero r0", 0, 128'd0);
        wait_cyc(5);
        check_round("zero r1", 1, zero_r1);
        wait_cyc(45);
        check_round("zero r10", 10, zero_r10);
        wait_cyc(1);
        check_idle("zero done");

        // Back-pressure on round 4 for 3 cycles.
        load_key(a1[0]);
        wait_cyc(20);
        check_round("bp r4", 4, a1[4]);
        rkey_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check_round($sformatf("bp hold%0d", i), 4, a1[4]);
        end
        rkey_ready = 1'b1;
        wait_cyc(4);
        check("bp r5 early", 128'(rkey_valid), 128'd0);
        wait_cyc(1);
        check_round("bp r5", 5, a1[5]);
        wait_cyc(25);
        check_round("bp r10", 10, a1[10]);
        wait_cyc(1);
        check_idle("bp done");

        // Stray key_valid during SUB of round 2.
        load_key(a1[0]);
        wait_cyc(12);
        key       = 128'd0;
        key_valid = 1'b1;
        wait_cyc(1);
        key_valid = 1'b0;
        wait_cyc(2);
        check_round("stray r3", 3, a1[3]);
        wait_cyc(35);
        check_round("stray r10", 10, a1[10]);
        wait_cyc(1);
        check_idle("stray done");

        // Asynchronous reset mid-SUB, then a fresh key.
        load_key(a1[0]);
        wait_cyc(7);
        #2 sys_rst = 1'b1;
        #1;
        check("arst key", rk_out, 128'd0);
        check("arst idx", 128'(round_idx), 128'd0);
        check_idle("arst");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_cyc(1);
        load_key(128'd0);
        check_round("arst new r0", 0, 128'd0);
        wait_cyc(5);
        check_round("arst new r1", 1, zero_r1);
        wait_cyc(45);
        check_round("arst new r10", 10, zero_r10);
        wait_cyc(1);
        check_idle("arst done");

        // Back-to-back keys: second key_valid held from cycle 50.
        load_key(a1[0]);
        wait_cyc(49);
        key       = 128'd0;
        key_valid = 1'b1;
        wait_cyc(1);
        check_round("b2b first r10", 10, a1[10]);
        wait_cyc(1);
        check("b2b c52 key_ready", 128'(key_ready), 128'd1);
        check("b2b c52 valid", 128'(rkey_valid), 128'd0);
        wait_cyc(1);
        key_valid = 1'b0;
        check_round("b2b second r0", 0, 128'd0);
        wait_cyc(5);
        check_round("b2b second r1", 1, zero_r1);
        wait_cyc(45);
        check_round("b2b second r10", 10, zero_r10);
        wait_cyc(1);
        check_idle("b2b done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key schedule producing the round keys that the AddRoundKey stage consumes, in the same byte order (`round_key_out0..15` connect directly to `round_key_in0..15`). It accepts one 128-bit cipher key over a valid/ready handshake, then emits round keys 0 through 10 one at a time under consumer back-pressure. It sits between the key-load interface and the cipher datapath. A single shared S-box lookup keeps area low at the cost of 5 cycles per round key.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- `sys_clk` input 1: single clock, rising edge.
- `sys_rst` input 1: asynchronous, active-high reset.
- `key_in0`..`key_in15` input 8 each: cipher key bytes, FIPS-197 order (byte i = word i/4, row i%4).
- `key_valid` input 1: key bytes valid.
- `key_ready` output 1: expander idle, key accepted on `key_valid & key_ready`.
- `round_key_out0`..`round_key_out15` output 8 each, registered: current round key, same byte order.
- `round_idx` output 4: index 0..10 of the presented round key.
- `rkey_valid` output 1: round key outputs valid.
- `rkey_ready` input 1: consumer accepts on `rkey_valid & rkey_ready`.
- `busy` output 1: high whenever not IDLE.

## Operation
- States: IDLE, OUT, SUB.
- IDLE:
  - `key_ready=1`, `rkey_valid=0`.
  - On key handshake, latch `key_in*` into `round_key_out*`, set `round_idx=0`, go to OUT.
- OUT:
  - `rkey_valid=1`; all outputs held stable until the handshake.
  - On handshake with `round_idx==10`, go to IDLE.
  - On handshake otherwise, go to SUB with `sub_cnt=0`.
- SUB (4 cycles, `sub_cnt` 0..3):
  - `rot = RotWord(w3) = {b13,b14,b15,b12}`.
  - Cycle j: `sub[j] <= sbox(rot[j])`, using one S-box instance implementing the FIPS-197 forward S-box.
  - On `sub_cnt==3`, compute `temp = sub ^ {rcon,00,00,00}`:
    - `w0' = w0 ^ temp`
    - `w1' = w1 ^ w0'`
    - `w2' = w2 ^ w1'`
    - `w3' = w3 ^ w2'`
  - In the same edge, load these into `round_key_out*`, increment `round_idx`, and go to OUT.
- Rcon for new index r = 1..10: 01,02,04,08,10,20,40,80,1b,36. All byte arithmetic is 8-bit XOR with no carries.
- `key_valid` is ignored outside IDLE.
- `rkey_ready` is ignored outside OUT.
- Async reset in any state forces IDLE immediately, discarding any in-flight expansion.

## Timing
- Reset values:
  - `round_key_out*=0`, `round_idx=0`, `rkey_valid=0`, `busy=0`, `key_ready=1`.
  - Internal: `sub*=0`, `sub_cnt=0`.
- Key handshake at edge 0 → `rkey_valid=1` with round 0 from edge 0 output (cycle 1).
- `rkey_ready` held high throughout:
  - Round r is presented from cycle 1+5r.
  - Round 10 is presented at cycle 51.
  - `key_ready` returns high at cycle 52.
- Round-key handshake → next `rkey_valid` exactly 5 cycles later: 4 SUB cycles plus the load edge.
- `rkey_valid` is low during SUB.
- Back-pressure adds zero extra latency beyond the stall itself.
- `key_ready` and `busy` are decoded from the state register, with no combinational path from inputs.
- Key handshake and reset asserted together: reset wins.

## Test plan
- FIPS-197 A.1 key `2b7e151628aed2a6abf7158809cf4f3c`, `rkey_ready=1`:
  - round 0 equals the key at cycle 1.
  - round 1 = `a0fafe1788542cb123a339392a6c7605` at cycle 6.
  - round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` at cycle 51.
  - `key_ready=1` at cycle 52.
- All-zero key:
  - round 1 = `62636363626363636263636362636363`.
  - round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Back-pressure: drop `rkey_ready` for 3 cycles while round 4 is presented → outputs and `round_idx=4` stable, `rkey_valid` held high. Round 5 appears 5 cycles after the eventual handshake.
- `key_valid` pulsed with a different key during SUB of round 2 → ignored; the rest of the schedule matches the original key.
- Assert `sys_rst` asynchronously mid-SUB (between edges) → outputs immediately return to reset values. A new key after release expands correctly from round 0.
- Two keys back-to-back (second `key_valid` held from cycle 50) → second key accepted at edge 52, its round 0 presented at cycle 53.
